// File: rtl/sram_fifo_ctrl_if.sv
// Producer/consumer side of the SRAM-backed FIFO: push and pop handshakes plus fill status.
// The master side drives requests; the slave side (the controller) grants them and returns data.
interface sram_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic                  wr_valid;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ready;
   logic                  rd_req;
   logic                  rd_ready;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [ADDR_WIDTH:0]   level;
   logic                  full;
   logic                  empty;

   modport master (
      output wr_valid, wr_data, rd_req,
      input  wr_ready, rd_ready, rd_valid, rd_data, level, full, empty
   );

   modport slave (
      input  wr_valid, wr_data, rd_req,
      output wr_ready, rd_ready, rd_valid, rd_data, level, full, empty
   );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over a single-port synchronous SRAM: arbitrates pushes and pops
// into one-cycle RAM writes and two-cycle RAM reads (issue, then capture).
module sram_fifo_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   sram_fifo_ctrl_if.slave       fifo,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_oe,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);
   typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_CAPTURE} state_t;
   typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_t                state;
   state_t                next_state;
   grant_t                last_grant;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   level;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;
   logic                  full;
   logic                  empty;
   logic                  wr_cand;
   logic                  rd_cand;
   logic                  push;
   logic                  pop;

   assign full    = (level == DEPTH);
   assign empty   = (level == '0);
   assign wr_cand = fifo.wr_valid && !full;
   assign rd_cand = fifo.rd_req && !empty;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      push       = 1'b0;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            // Round-robin on contention: the side not granted last time wins.
            push = !rst && wr_cand && (!rd_cand || last_grant == GRANT_READ);
            pop  = !rst && rd_cand && (!wr_cand || last_grant == GRANT_WRITE);
            if (push)     next_state = WRITE;
            else if (pop) next_state = RD_ISSUE;
         end
         WRITE:      next_state = IDLE;
         RD_ISSUE:   next_state = RD_CAPTURE;
         RD_CAPTURE: next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         wdata_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         last_grant  <= GRANT_READ;
         ram_address <= '0;
         ram_cs      <= 1'b0;
         ram_we      <= 1'b0;
         ram_oe      <= 1'b0;
      end else begin
         // RAM strobes are registered from the next state so they align with WRITE/RD_* exactly.
         ram_cs     <= (next_state != IDLE);
         ram_we     <= (next_state == WRITE);
         ram_oe     <= (next_state == RD_ISSUE) || (next_state == RD_CAPTURE);
         rd_valid_q <= (state == RD_CAPTURE);
         if (state == RD_CAPTURE) rd_data_q <= ram_rdata;

         if (push) begin
            ram_address <= wr_ptr;
            wdata_q     <= fifo.wr_data;
            wr_ptr      <= wr_ptr + ADDR_WIDTH'(1);
            level       <= level + (ADDR_WIDTH + 1)'(1);
            last_grant  <= GRANT_WRITE;
         end else if (pop) begin
            ram_address <= rd_ptr;
            rd_ptr      <= rd_ptr + ADDR_WIDTH'(1);
            level       <= level - (ADDR_WIDTH + 1)'(1);
            last_grant  <= GRANT_READ;
         end
      end
   end

   // Write data is only presented while the RAM is being written; the bus is quiet otherwise.
   assign ram_wdata = ram_we ? wdata_q : '0;

   assign fifo.wr_ready = push;
   assign fifo.rd_ready = pop;
   assign fifo.rd_valid = rd_valid_q;
   assign fifo.rd_data  = rd_data_q;
   assign fifo.level    = level;
   assign fifo.full     = full;
   assign fifo.empty    = empty;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl (4-deep, 8-bit) with a behavioural RAM and a
// queue-based FIFO model that predicts grants, RAM strobes, level and read data every cycle.
module tb_sram_fifo_ctrl;
   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          rst;
   logic [AW-1:0] ram_address;
   logic          ram_cs;
   logic          ram_we;
   logic          ram_oe;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic [DW-1:0] mem [DEPTH];

   int errors = 0;
   int checks = 0;

   sram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .fifo        (bus),
      .ram_address (ram_address),
      .ram_cs      (ram_cs),
      .ram_we      (ram_we),
      .ram_oe      (ram_oe),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port synchronous RAM: write on we, registered read data on oe.
   always @(posedge clk) begin
      if (ram_cs && ram_we) mem[ram_address] <= ram_wdata;
      if (ram_cs && ram_oe && !ram_we) ram_rdata <= mem[ram_address];
   end

   // Reference model state
   logic [DW-1:0] m_q [$];
   int            m_wp, m_rp;
   bit            last_rd;
   int            cyc;
   int            idle_at;
   int            wr_at, wr_addr;
   logic [DW-1:0] wr_dat;
   int            rd_at, rd_addr;
   int            rv_at;
   logic [DW-1:0] rv_dat;
   logic [DW-1:0] last_rd_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_wp         = 0;
      m_rp         = 0;
      last_rd      = 1'b1;
      idle_at      = 0;
      wr_at        = -100;
      rd_at        = -100;
      rv_at        = -100;
      last_rd_data = '0;
   endtask

   // One clock cycle: apply inputs, compare at the falling edge, advance the model.
   task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr);
      bit idle, wc, rc, exp_w, exp_r, rd_cyc;
      bus.wr_valid = wv;
      bus.wr_data  = wd;
      bus.rd_req   = rr;
      @(negedge clk);
      idle   = (cyc >= idle_at);
      wc     = wv && (m_q.size() < DEPTH);
      rc     = rr && (m_q.size() > 0);
      exp_w  = idle && wc && (!rc || last_rd);
      exp_r  = idle && rc && (!wc || !last_rd);
      rd_cyc = (cyc == rd_at) || (cyc == rd_at + 1);
      chk("wr_ready", bus.wr_ready, exp_w);
      chk("rd_ready", bus.rd_ready, exp_r);
      chk("level", bus.level, m_q.size());
      chk("full", bus.full, m_q.size() == DEPTH);
      chk("empty", bus.empty, m_q.size() == 0);
      chk("rd_valid", bus.rd_valid, cyc == rv_at);
      if (cyc == rv_at) begin
         chk("rd_data", bus.rd_data, rv_dat);
         last_rd_data = rv_dat;
      end else begin
         chk("rd_data_hold", bus.rd_data, last_rd_data);
      end
      chk("ram_cs", ram_cs, (cyc == wr_at) || rd_cyc);
      chk("ram_we", ram_we, cyc == wr_at);
      chk("ram_oe", ram_oe, rd_cyc);
      if (cyc == wr_at) begin
         chk("wr_addr", ram_address, wr_addr);
         chk("wr_data", ram_wdata, wr_dat);
      end else begin
         chk("wdata_quiet", ram_wdata, 0);
      end
      if (rd_cyc) chk("rd_addr", ram_address, rd_addr);
      if (exp_w) begin
         m_q.push_back(wd);
         wr_at   = cyc + 1;
         wr_addr = m_wp;
         wr_dat  = wd;
         m_wp    = (m_wp + 1) % DEPTH;
         idle_at = cyc + 2;
         last_rd = 1'b0;
      end
      if (exp_r) begin
         rv_dat  = m_q.pop_front();
         rd_at   = cyc + 1;
         rd_addr = m_rp;
         rv_at   = cyc + 3;
         m_rp    = (m_rp + 1) % DEPTH;
         idle_at = cyc + 3;
         last_rd = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push(input logic [DW-1:0] d);
      step(1'b1, d, 1'b0);
      step(1'b0, '0, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, '0, 1'b1);
      repeat (2) step(1'b0, '0, 1'b0);
   endtask

   initial begin
      cyc = 0;
      model_reset();
      rst          = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'hA5;
      bus.rd_req   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_ready", bus.wr_ready, 0);
      chk("rst_rd_ready", bus.rd_ready, 0);
      chk("rst_level", bus.level, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_ram_ctl", {ram_cs, ram_we, ram_oe}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Fill to full, then keep pushing: refused with no change.
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      step(1'b1, 8'h55, 1'b0);
      step(1'b1, 8'h66, 1'b0);
      chk("full_after_fill", bus.full, 1);
      chk("level_after_fill", bus.level, 4);

      // Drain in order, then keep popping: refused.
      repeat (4) pop();
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      chk("empty_after_drain", bus.empty, 1);
      chk("last_pop_data", bus.rd_data, 8'h44);

      // Level 2 with last grant = read, both sides held: alternate write/read.
      push(8'hA1); push(8'hA2); push(8'hA3);
      pop();
      step(1'b0, '0, 1'b0);
      chk("level_before_contend", bus.level, 2);
      repeat (16) begin
         step(1'b1, 8'($urandom), 1'b1);
         chk("level_2_or_3", bus.level inside {3'd2, 3'd3}, 1);
      end

      // Empty out, then six push/pop pairs to wrap both pointers.
      repeat (24) begin
         if (m_q.size() > 0) step(1'b0, '0, 1'b1);
         else                step(1'b0, '0, 1'b0);
      end
      chk("empty_before_wrap", bus.empty, 1);
      for (int i = 0; i < 6; i++) begin
         push(8'hC0 + 8'(i));
         pop();
      end
      step(1'b0, '0, 1'b0);
      chk("wrap_last_data", bus.rd_data, 8'hC5);

      // Random traffic against the model.
      repeat (400) step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      repeat (24) begin
         if (m_q.size() > 0) step(1'b0, '0, 1'b1);
         else                step(1'b0, '0, 1'b0);
      end

      // Reset while the read is in RD_ISSUE: access aborted, no rd_valid afterwards.
      push(8'h5A);
      step(1'b0, '0, 1'b1);
      chk("issue_oe", ram_oe, 1);
      chk("issue_cs", ram_cs, 1);
      rst = 1'b1;
      #1;
      chk("abort_ram_ctl", {ram_cs, ram_we, ram_oe}, 0);
      chk("abort_level", bus.level, 0);
      chk("abort_empty", bus.empty, 1);
      chk("abort_rd_valid", bus.rd_valid, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
      repeat (6) step(1'b0, '0, 1'b0);

      // Controller usable again after the aborted read.
      push(8'h77);
      pop();
      step(1'b0, '0, 1'b0);
      chk("post_reset_data", bus.rd_data, 8'h77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
